// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared widths, types and constants for the register file.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;
    localparam int DEFAULT_DATA_WIDTH    = 64;
    localparam int DEFAULT_ADDRESS_WIDTH = 5;

    typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0]    reg_data_t;

    localparam reg_addr_t ZERO_ADDR = '0;
endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Pending-write bit per register with issue/flush/write priority.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int REGISTER_SIZE = 2**ADDRESS_WIDTH,
    parameter int ZERO_REG      = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_iss_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_iss_rd,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [ADDRESS_WIDTH-1:0] i_wr_addr,
    output logic [REGISTER_SIZE-1:0] o_pending,
    output logic [ADDRESS_WIDTH:0]   o_pending_cnt
);

    logic [REGISTER_SIZE-1:0] r_pending;
    logic [ADDRESS_WIDTH:0]   r_pending_cnt;
    logic [REGISTER_SIZE-1:0] w_pending_nxt;
    logic [ADDRESS_WIDTH:0]   w_cnt_nxt;

    // A new producer outranks flush, which outranks the writeback clear.
    for (genvar r = 0; r < REGISTER_SIZE; r++) begin : g_bit
        localparam logic [ADDRESS_WIDTH-1:0] c_IDX  = ADDRESS_WIDTH'(r);
        localparam bit                       c_TIED = (ZERO_REG != 0) && (r == 0);

        assign w_pending_nxt[r] = c_TIED                                ? 1'b0 :
                                  (i_iss_valid && i_iss_rd == c_IDX)    ? 1'b1 :
                                  i_flush                               ? 1'b0 :
                                  (i_wr_en && i_wr_addr == c_IDX)       ? 1'b0 :
                                                                          r_pending[r];
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < REGISTER_SIZE; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{ADDRESS_WIDTH{1'b0}}, w_pending_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending     <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_pending     <= w_pending_nxt;
            r_pending_cnt <= w_cnt_nxt;
        end
    end

    assign o_pending     = r_pending;
    assign o_pending_cnt = r_pending_cnt;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
//  Module      : regfile_sb
//  Description : Multi-port integer register file with bypass and scoreboard.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int REGISTER_SIZE = 2**ADDRESS_WIDTH,
    parameter int NUM_READ      = 2,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              RegWrite,
    input  logic [ADDRESS_WIDTH-1:0]          wa,
    input  logic [DATA_WIDTH-1:0]             wd,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] ra,
    output logic [NUM_READ*DATA_WIDTH-1:0]    rd,
    output logic [NUM_READ-1:0]               rd_ready,
    input  logic                              iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]          iss_rd,
    input  logic                              flush,
    output logic [REGISTER_SIZE-1:0]          pending,
    output logic [ADDRESS_WIDTH:0]            pending_cnt
);

    localparam logic [ADDRESS_WIDTH-1:0] c_ZERO = ADDRESS_WIDTH'(ZERO_ADDR);

    logic [DATA_WIDTH-1:0]    r_regs [REGISTER_SIZE];
    logic [REGISTER_SIZE-1:0] w_pending;
    logic                     w_we;

    // Writes to x0 are dropped so neither storage nor bypass ever sees them.
    assign w_we = RegWrite && !((ZERO_REG != 0) && (wa == c_ZERO));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < REGISTER_SIZE; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_we) begin
            r_regs[wa] <= wd;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] w_ra;
        logic                     w_hit;
        logic                     w_zero;

        assign w_ra   = ra[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign w_hit  = (BYPASS != 0) && w_we && (wa == w_ra);
        assign w_zero = (ZERO_REG != 0) && (w_ra == c_ZERO);

        assign rd[i*DATA_WIDTH +: DATA_WIDTH] = w_zero ? '0 :
                                                w_hit  ? wd :
                                                         r_regs[w_ra];
        assign rd_ready[i] = w_zero || w_hit || !w_pending[w_ra];
    end

    reg_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .REGISTER_SIZE (REGISTER_SIZE),
        .ZERO_REG      (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_iss_valid   (iss_valid),
        .i_iss_rd      (iss_rd),
        .i_flush       (flush),
        .i_wr_en       (RegWrite),
        .i_wr_addr     (wa),
        .o_pending     (w_pending),
        .o_pending_cnt (pending_cnt)
    );

    assign pending = w_pending;

endmodule

`default_nettype wire
